frame_stream_ctrl: RTL and testbench
====================================

Name: frame_stream_ctrl

Overview:
- Synthesizable per-frame pixel sequencer; replaces the bench-side read/process/collect loop around the image processing core.
- Reads each pixel from the source image RAM, presents it to the core via the done_in/done_out handshake, and writes the result to a destination RAM.
- Generalised in pixel count, channel width and channel count; adds a RAM-latency parameter, a per-pixel timeout, an abort input and status reporting.

Parameters:
- PIXELS, 41750, pixels per frame; addresses 0..PIXELS-1.
- ADDR_W, 16, RAM address width; must satisfy PIXELS <= 2**ADDR_W.
- CH_W, 8, bits per colour channel.
- CHANNELS, 3, channels per pixel; pixel width PIX_W = CH_W*CHANNELS, packed {ch[CHANNELS-1]..ch[0]} (red in the MSBs).
- RD_LAT, 1, source RAM read latency in cycles (1..4).
- TIMEOUT, 64, maximum cycles to wait for proc_done after issue.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle, ignored otherwise.
- abort  in  1  synchronous abort; returns to IDLE at the next edge.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- frame_done  out  1  one-cycle pulse when the last pixel is written or on timeout.
- timeout_err  out  1  sticky; set on timeout, cleared by the next accepted start.
- src_en  out  1  source RAM enable.
- src_addr  out  ADDR_W  source read address.
- src_data  in  PIX_W  source read data, valid RD_LAT cycles after src_en.
- proc_start  out  1  to core done_in; one-cycle pulse with proc_pix valid.
- proc_pix  out  PIX_W  pixel presented to the core.
- proc_done  in  1  core done_out.
- proc_res  in  PIX_W  core result, valid while proc_done is high.
- dst_we  out  1  destination write strobe, one cycle per pixel.
- dst_addr  out  ADDR_W  destination address, equal to the pixel index.
- dst_data  out  PIX_W  registered copy of proc_res.

Behaviour:
- Reset: all outputs 0, state IDLE, pixel index 0, timeout_err 0.
- States and transitions:
  - IDLE: on start, set idx=0, clear timeout_err, go to FETCH.
  - FETCH: src_en=1, src_addr=idx for one cycle; go to WAIT.
  - WAIT: count RD_LAT-1 further cycles, then capture src_data into proc_pix; go to ISSUE.
  - ISSUE: proc_start=1 for one cycle; clear the timer; go to COLLECT.
  - COLLECT: while proc_done=1, register proc_res into dst_data and go to WRITE. Otherwise increment the timer; when the timer reaches TIMEOUT, set timeout_err and go to DONE. The remaining pixels are not written.
  - WRITE: dst_we=1, dst_addr=idx. If idx==PIXELS-1, go to DONE; else idx+1 and go to FETCH.
  - DONE: frame_done=1 for one cycle; go to IDLE.
- Per-pixel latency: 3 + RD_LAT + k cycles, where k>=1 is the number of COLLECT cycles including the proc_done cycle. With a core responding in 1 cycle and RD_LAT=1: 5 cycles per pixel.
- proc_done seen in any state other than COLLECT is ignored; it does not cause a write.
- start while busy is ignored.
- If abort and start arrive in the same cycle, abort wins and the state is IDLE.
- Abort mid-frame: no further src_en or dst_we, no frame_done, timeout_err unchanged.
- Reset asserted mid-operation: all outputs clear immediately; the partially written frame is left as is.
- idx is ADDR_W bits and never wraps, because PIXELS <= 2**ADDR_W.
- No arithmetic is performed on pixel data; pixels are passed through bit-exact.

Optional Feature:
- Macro: FRAME_STREAM_CHECKSUM_EN.
- When defined:
  - Adds output frame_sum [31:0].
  - On each dst_we, frame_sum += zero-extended dst_data, modulo 2^32.
  - frame_sum clears on an accepted start and holds its value after DONE.
- When undefined: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package image_proc_pkg holds: CH_W, CHANNELS and PIX_W constants; the pixel_t typedef; the stream_state_t enum {IDLE, FETCH, WAIT, ISSUE, COLLECT, WRITE, DONE}.
- Sub-module frame_checksum: the accumulator, instantiated only under FRAME_STREAM_CHECKSUM_EN.
- The timer and index counter stay inline.

Test Plan:
- PIXELS=4, RD_LAT=1, core echoes the input with 1-cycle done; src = {0x102030, 0xFFFFFF, 0x000000, 0x7F7F7F} -> dst holds the same 4 words at addresses 0..3, exactly 4 dst_we pulses, frame_done 20 cycles after start, busy then drops.
- RD_LAT=3, core threshold 80 on 0x505050 / 0x4F4F4F -> dst = 0xFFFFFF / 0x000000, 7 cycles per pixel.
- Core never asserts proc_done, TIMEOUT=8 -> no dst_we, timeout_err=1 and frame_done pulses 12 cycles after start; a new start clears timeout_err.
- abort at the COLLECT of pixel 2 -> dst_we only at addresses 0 and 1, no frame_done, busy=0 the next cycle; start pulsed while busy is ignored (address sequence unchanged).
- reset low for 1 cycle mid-WRITE -> all outputs 0 asynchronously; after release, a fresh start completes a full frame.
- FRAME_STREAM_CHECKSUM_EN defined, 3 pixels {1, 2, 0xFFFFFF} -> frame_sum = 0x01000002.

Source files
------------

// File: rtl/image_proc_pkg.sv
// -----------------------------------------------------------------------------
// image_proc_pkg
// Shared definitions for the image-processing frame sequencer:
//   CH_W, CHANNELS, PIX_W : default pixel geometry (8-bit RGB, red in MSBs)
//   pixel_t               : packed pixel {ch[CHANNELS-1] .. ch[0]}
//   stream_state_t        : per-pixel sequencing states of frame_stream_ctrl
// -----------------------------------------------------------------------------
package image_proc_pkg;

  localparam int CH_W     = 8;
  localparam int CHANNELS = 3;
  localparam int PIX_W    = CH_W * CHANNELS;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    COLLECT,
    WRITE,
    DONE
  } stream_state_t;

endpackage

// File: rtl/frame_checksum.sv
// -----------------------------------------------------------------------------
// frame_checksum
// Running modulo-2^32 sum of every pixel written to the destination RAM.
// Only instantiated when FRAME_STREAM_CHECKSUM_EN is defined.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   clear    : zero the sum (accepted frame start)
//   add_en   : add add_data this cycle (destination write strobe)
//   add_data : pixel being written, zero-extended before the add
//   sum      : accumulated frame checksum; holds between frames
// -----------------------------------------------------------------------------
module frame_checksum #(
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [PIX_W-1:0] add_data,
  output logic [31:0]      sum
);

  logic [31:0] r_sum;
  logic [31:0] w_ext;

  // Pixels wider than 32 bits contribute only their low word.
  assign w_ext = 32'(add_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (add_en) begin
      r_sum <= r_sum + w_ext;
    end
  end

  assign sum = r_sum;

endmodule

// File: rtl/frame_stream_ctrl.sv
// -----------------------------------------------------------------------------
// frame_stream_ctrl
// Per-frame pixel sequencer: reads each pixel from the source RAM, hands it
// to the processing core over the proc_start/proc_done handshake and writes
// the result to the destination RAM at the same index.
// Optional feature: define FRAME_STREAM_CHECKSUM_EN to add output frame_sum.
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-low reset
//   start, abort   : frame start pulse (idle only); synchronous abort
//   busy           : frame in progress (cycle after accepted start .. DONE)
//   frame_done     : one-cycle pulse on last write or on timeout
//   timeout_err    : sticky core-timeout flag, cleared by accepted start
//   src_en/addr/data : source RAM read port, data RD_LAT cycles after src_en
//   proc_start/pix : pixel handed to the core (one-cycle strobe)
//   proc_done/res  : core result, valid while proc_done is high
//   dst_we/addr/data : destination RAM write port
//   frame_sum      : (FRAME_STREAM_CHECKSUM_EN) sum of written pixels mod 2^32
// -----------------------------------------------------------------------------
module frame_stream_ctrl #(
  parameter int PIXELS   = 41750,
  parameter int ADDR_W   = 16,
  parameter int CH_W     = 8,
  parameter int CHANNELS = 3,
  parameter int RD_LAT   = 1,
  parameter int TIMEOUT  = 64,
  localparam int PIX_W   = CH_W * CHANNELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic              proc_start,
  output logic [PIX_W-1:0]  proc_pix,
  input  logic              proc_done,
  input  logic [PIX_W-1:0]  proc_res,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data
`ifdef FRAME_STREAM_CHECKSUM_EN
  ,
  output logic [31:0]       frame_sum
`endif
);

  import image_proc_pkg::*;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W = 3;

  stream_state_t     r_state;
  stream_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [LAT_W-1:0]  r_lat;
  logic [TMR_W-1:0]  r_timer;
  logic [PIX_W-1:0]  r_pix;
  logic [PIX_W-1:0]  r_dst_data;
  logic              r_timeout_err;

  logic w_accept;
  logic w_last_pix;
  logic w_lat_done;
  logic w_timer_hit;
  logic w_timeout;

  // A start coinciding with abort is dropped: abort always wins.
  assign w_accept    = (r_state == IDLE) && start && !abort;
  assign w_last_pix  = (r_idx == ADDR_W'(PIXELS - 1));
  assign w_lat_done  = (r_lat == LAT_W'(RD_LAT - 1));
  assign w_timer_hit = (r_timer == TMR_W'(TIMEOUT));
  assign w_timeout   = (r_state == COLLECT) && !proc_done && w_timer_hit && !abort;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps every path of this block
  // assigned, so no latch is inferred for unlisted cases.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = WAIT;
      WAIT:    if (w_lat_done) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = COLLECT;
      COLLECT: begin
        if (proc_done)        w_state_nxt = WRITE;
        else if (w_timer_hit) w_state_nxt = DONE;
      end
      WRITE:   w_state_nxt = w_last_pix ? DONE : FETCH;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // NOTE: datapath registers are reset too, so every output reads 0 the
  // moment reset asserts, not just the state-decoded strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx         <= '0;
      r_lat         <= '0;
      r_timer       <= '0;
      r_pix         <= '0;
      r_dst_data    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx <= '0;
      end else if ((r_state == WRITE) && !w_last_pix && !abort) begin
        r_idx <= r_idx + ADDR_W'(1);
      end

      // Latency counter: FETCH arms it, WAIT counts up to RD_LAT-1.
      if (r_state == FETCH) begin
        r_lat <= '0;
      end else if (r_state == WAIT) begin
        r_lat <= r_lat + LAT_W'(1);
      end

      if ((r_state == WAIT) && w_lat_done) begin
        r_pix <= src_data;
      end

      // Timer saturates at TIMEOUT; the COLLECT cycle that sees it exits.
      if (r_state == ISSUE) begin
        r_timer <= '0;
      end else if ((r_state == COLLECT) && !proc_done && !w_timer_hit) begin
        r_timer <= r_timer + TMR_W'(1);
      end

      if ((r_state == COLLECT) && proc_done) begin
        r_dst_data <= proc_res;
      end

      if (w_accept) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign frame_done  = (r_state == DONE);
  assign src_en      = (r_state == FETCH);
  assign proc_start  = (r_state == ISSUE);
  assign dst_we      = (r_state == WRITE);
  assign src_addr    = r_idx;
  assign dst_addr    = r_idx;
  assign proc_pix    = r_pix;
  assign dst_data    = r_dst_data;
  assign timeout_err = r_timeout_err;

`ifdef FRAME_STREAM_CHECKSUM_EN
  frame_checksum #(
    .PIX_W (PIX_W)
  ) u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_accept),
    .add_en   (dst_we),
    .add_data (dst_data),
    .sum      (frame_sum)
  );
`endif

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_stream_ctrl
// Directed bench for frame_stream_ctrl. Instance A: PIXELS=4, RD_LAT=1,
// TIMEOUT=8 with an echo/silent/always-done core. Instance B: PIXELS=2,
// RD_LAT=3 with a per-channel threshold-80 core.
// Cycle numbering: cycle 0 is the first cycle after the edge that accepts
// start; cycle c is sampled on the falling edge after c further rising edges.
// -----------------------------------------------------------------------------
module tb_frame_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A
  logic        a_start, a_abort, a_busy, a_fd, a_terr, a_src_en, a_pstart, a_pdone, a_dst_we;
  logic [15:0] a_src_addr, a_dst_addr;
  logic [23:0] a_src_data = '0, a_pix, a_res = '0, a_dst_data;
  // Instance B
  logic        b_start, b_abort, b_busy, b_fd, b_terr, b_src_en, b_pstart, b_pdone, b_dst_we;
  logic [15:0] b_src_addr, b_dst_addr;
  logic [23:0] b_src_data, b_pix, b_res = '0, b_dst_data;
`ifdef FRAME_STREAM_CHECKSUM_EN
  logic [31:0] a_sum, b_sum;
`endif

  frame_stream_ctrl #(
    .PIXELS(4), .ADDR_W(16), .CH_W(8), .CHANNELS(3), .RD_LAT(1), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
    .busy(a_busy), .frame_done(a_fd), .timeout_err(a_terr),
    .src_en(a_src_en), .src_addr(a_src_addr), .src_data(a_src_data),
    .proc_start(a_pstart), .proc_pix(a_pix), .proc_done(a_pdone), .proc_res(a_res),
    .dst_we(a_dst_we), .dst_addr(a_dst_addr), .dst_data(a_dst_data)
`ifdef FRAME_STREAM_CHECKSUM_EN
    , .frame_sum(a_sum)
`endif
  );

  frame_stream_ctrl #(
    .PIXELS(2), .ADDR_W(16), .CH_W(8), .CHANNELS(3), .RD_LAT(3), .TIMEOUT(8)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
    .busy(b_busy), .frame_done(b_fd), .timeout_err(b_terr),
    .src_en(b_src_en), .src_addr(b_src_addr), .src_data(b_src_data),
    .proc_start(b_pstart), .proc_pix(b_pix), .proc_done(b_pdone), .proc_res(b_res),
    .dst_we(b_dst_we), .dst_addr(b_dst_addr), .dst_data(b_dst_data)
`ifdef FRAME_STREAM_CHECKSUM_EN
    , .frame_sum(b_sum)
`endif
  );

  // ---------------- environment models (RAMs and cores) ----------------
  logic [23:0] src_a [0:3];
  logic [23:0] src_b [0:1];
  int          core_mode = 0;  // 0: echo after 1 cycle, 1: silent, 2: done stuck high
  logic [23:0] b_p1 = '0, b_p2 = '0, b_p3 = '0;
  logic        a_pdone_r = 1'b0, b_pdone_r = 1'b0;

  assign a_pdone    = a_pdone_r;
  assign b_pdone    = b_pdone_r;
  assign b_src_data = b_p3;

  function automatic logic [23:0] thresh80(input logic [23:0] p);
    logic [23:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++) r[ch*8 +: 8] = (p[ch*8 +: 8] >= 8'd80) ? 8'hFF : 8'h00;
    return r;
  endfunction

  always @(posedge clk) begin
    a_src_data <= a_src_en ? src_a[a_src_addr[1:0]] : 24'h0;
    a_pdone_r  <= (core_mode == 2) || ((core_mode == 0) && a_pstart);
    a_res      <= a_pix;
    b_p1       <= b_src_en ? src_b[b_src_addr[0]] : 24'h0;
    b_p2       <= b_p1;
    b_p3       <= b_p2;
    b_pdone_r  <= b_pstart;
    b_res      <= thresh80(b_pix);
  end

  // ---------------- bookkeeping ----------------
  int          total = 0;
  int          bad   = 0;
  logic [23:0] dst_a [0:3];
  int          we_addr [$];
  int          we_cyc  [$];
  int          n_fetch;

  // Pulses start on A, then watches `budget` cycles, optionally asserting
  // abort, a second start or a one-cycle reset after sampling the given cycle.
  task automatic run_a(input int budget, input int abort_at, input int restart_at,
                       input int reset_at, output int fd_cyc, output int drop_cyc);
    we_addr.delete();
    we_cyc.delete();
    n_fetch = 0;
    for (int i = 0; i < 4; i++) dst_a[i] = 24'h5A5A5A;
    fd_cyc   = -1;
    drop_cyc = -1;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    total++;
    if (a_busy !== 1'b1) begin bad++; $display("FAIL busy_on_start got=%b want=1", a_busy); end
    total++;
    if (a_terr !== 1'b0) begin bad++; $display("FAIL terr_clear_on_start got=%b want=0", a_terr); end
    if (a_src_en) n_fetch++;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      a_start = 1'b0;
      a_abort = 1'b0;
      if (a_src_en) n_fetch++;
      if (a_dst_we) begin
        we_addr.push_back(int'(a_dst_addr));
        we_cyc.push_back(c);
        if (a_dst_addr < 16'd4) dst_a[a_dst_addr[1:0]] = a_dst_data;
      end
      if (a_fd && fd_cyc < 0) fd_cyc = c;
      if (!a_busy && drop_cyc < 0) drop_cyc = c;
      if (c == abort_at) a_abort = 1'b1;
      if (c == restart_at) a_start = 1'b1;
      if (c == reset_at) begin
        #2 reset = 1'b0;
        #1;
        total++;
        if ({a_busy, a_fd, a_terr, a_src_en, a_pstart, a_dst_we, a_src_addr, a_dst_addr,
             a_pix, a_dst_data} !== '0) begin
          bad++;
          $display("FAIL async_reset_outputs busy=%b fd=%b we=%b dst_addr=%h dst_data=%h want all 0",
                   a_busy, a_fd, a_dst_we, a_dst_addr, a_dst_data);
        end
        @(negedge clk) reset = 1'b1;
      end
    end
  endtask

  // Checks that the last run_a wrote `exp` to addresses 0..3 in order, at
  // 5-cycle spacing, with frame_done at cycle 20 and busy low at 21.
  task automatic check_full_frame(input string tag, input logic [23:0] exp [0:3],
                                  input int fd_cyc, input int drop_cyc);
    bit ok;
    ok = (we_addr.size() == 4) && (we_cyc.size() == 4);
    for (int i = 0; ok && i < 4; i++) ok = (we_addr[i] == i) && (we_cyc[i] == 4 + 5*i);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_write_seq writes=%0d addr=%p cyc=%p want addr 0..3 at 4,9,14,19",
               tag, we_addr.size(), we_addr, we_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dst_a[i] !== exp[i]) begin
        bad++; $display("FAIL %s_dst[%0d] got=%h want=%h", tag, i, dst_a[i], exp[i]);
      end
    end
    total++;
    if (fd_cyc !== 20) begin bad++; $display("FAIL %s_frame_done_cycle got=%0d want=20", tag, fd_cyc); end
    total++;
    if (drop_cyc !== 21) begin bad++; $display("FAIL %s_busy_drop_cycle got=%0d want=21", tag, drop_cyc); end
    total++;
    if (n_fetch !== 4) begin bad++; $display("FAIL %s_fetch_count got=%0d want=4", tag, n_fetch); end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b0; a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    #3;
    total++;
    if ({a_busy, a_fd, a_terr, a_src_en, a_pstart, a_dst_we, a_src_addr, a_dst_addr, a_pix, a_dst_data,
         b_busy, b_fd, b_terr, b_src_en, b_pstart, b_dst_we, b_src_addr, b_dst_addr, b_pix, b_dst_data}
        !== '0) begin
      bad++; $display("FAIL reset_outputs a_busy=%b b_busy=%b a_dst=%h want all 0", a_busy, b_busy, a_dst_data);
    end
`ifdef FRAME_STREAM_CHECKSUM_EN
    total++;
    if (a_sum !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h want=0", a_sum); end
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [23:0] exp [0:3];
    int fd, drop;
    exp = '{24'h102030, 24'hFFFFFF, 24'h000000, 24'h7F7F7F};
    for (int i = 0; i < 4; i++) src_a[i] = exp[i];
    core_mode = 0;
    run_a(25, -1, -1, -1, fd, drop);
    check_full_frame("stream", exp, fd, drop);
    total++;
    if (a_terr !== 1'b0) begin bad++; $display("FAIL stream_terr got=%b want=0", a_terr); end
  endtask

  task automatic test_done_outside_collect();
    logic [23:0] exp [0:3];
    int fd, drop;
    exp = '{24'hA1B2C3, 24'h010203, 24'hFEDCBA, 24'h00FF00};
    for (int i = 0; i < 4; i++) src_a[i] = exp[i];
    core_mode = 2;
    run_a(25, -1, -1, -1, fd, drop);
    check_full_frame("stuckdone", exp, fd, drop);
  endtask

  task automatic test_timeout();
    logic [23:0] exp [0:3];
    int fd, drop;
    exp = '{24'h102030, 24'hFFFFFF, 24'h000000, 24'h7F7F7F};
    for (int i = 0; i < 4; i++) src_a[i] = exp[i];
    core_mode = 1;
    run_a(16, -1, -1, -1, fd, drop);
    total++;
    if (we_addr.size() !== 0) begin bad++; $display("FAIL timeout_writes got=%0d want=0", we_addr.size()); end
    total++;
    if (fd !== 12) begin bad++; $display("FAIL timeout_frame_done_cycle got=%0d want=12", fd); end
    total++;
    if (drop !== 13) begin bad++; $display("FAIL timeout_busy_drop got=%0d want=13", drop); end
    total++;
    if (a_terr !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b want=1", a_terr); end
    // New start clears the flag (checked inside run_a) and runs a clean frame.
    core_mode = 0;
    run_a(25, -1, -1, -1, fd, drop);
    check_full_frame("after_timeout", exp, fd, drop);
    total++;
    if (a_terr !== 1'b0) begin bad++; $display("FAIL timeout_err_cleared got=%b want=0", a_terr); end
  endtask

  task automatic test_abort_and_busy_start();
    int fd, drop;
    bit ok;
    core_mode = 0;
    // Second start at cycle 7 (mid pixel 1) must be ignored; abort in
    // pixel 2's COLLECT cycle (13) while proc_done is high.
    run_a(25, 13, 7, -1, fd, drop);
    ok = (we_addr.size() == 2) && (we_addr[0] == 0) && (we_addr[1] == 1);
    total++;
    if (!ok) begin bad++; $display("FAIL abort_write_addrs got=%p want=0,1", we_addr); end
    total++;
    if (fd !== -1) begin bad++; $display("FAIL abort_frame_done got_cycle=%0d want=none", fd); end
    total++;
    if (drop !== 14) begin bad++; $display("FAIL abort_busy_drop got=%0d want=14", drop); end
    total++;
    if (n_fetch !== 3) begin bad++; $display("FAIL abort_fetch_count got=%0d want=3", n_fetch); end
  endtask

  task automatic test_reset_mid_write();
    logic [23:0] exp [0:3];
    int fd, drop;
    exp = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    for (int i = 0; i < 4; i++) src_a[i] = exp[i];
    core_mode = 0;
    run_a(25, -1, -1, 9, fd, drop);
    total++;
    if (we_addr.size() !== 2) begin bad++; $display("FAIL reset_partial_writes got=%0d want=2", we_addr.size()); end
    total++;
    if (fd !== -1) begin bad++; $display("FAIL reset_no_frame_done got_cycle=%0d want=none", fd); end
    run_a(25, -1, -1, -1, fd, drop);
    check_full_frame("post_reset", exp, fd, drop);
  endtask

  task automatic test_rd_lat3();
    logic [23:0] got [0:1];
    int wc [$];
    int fd;
    src_b[0] = 24'h505050;
    src_b[1] = 24'h4F4F4F;
    got[0] = 24'h5A5A5A;
    got[1] = 24'h5A5A5A;
    fd = -1;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_dst_we) begin
        wc.push_back(c);
        if (b_dst_addr < 16'd2) got[b_dst_addr[0]] = b_dst_data;
      end
      if (b_fd && fd < 0) fd = c;
    end
    total++;
    if (got[0] !== 24'hFFFFFF) begin bad++; $display("FAIL lat3_dst0 got=%h want=ffffff", got[0]); end
    total++;
    if (got[1] !== 24'h000000) begin bad++; $display("FAIL lat3_dst1 got=%h want=000000", got[1]); end
    total++;
    if (wc.size() !== 2 || wc[0] !== 6 || wc[1] !== 13) begin
      bad++; $display("FAIL lat3_write_cycles got=%p want=6,13", wc);
    end
    total++;
    if (fd !== 14) begin bad++; $display("FAIL lat3_frame_done_cycle got=%0d want=14", fd); end
`ifdef FRAME_STREAM_CHECKSUM_EN
    total++;
    if (b_sum !== 32'h00FFFFFF) begin bad++; $display("FAIL lat3_sum got=%h want=00ffffff", b_sum); end
`endif
  endtask

`ifdef FRAME_STREAM_CHECKSUM_EN
  task automatic test_checksum();
    int fd, drop;
    src_a[0] = 24'h000001; src_a[1] = 24'h000002; src_a[2] = 24'hFFFFFF; src_a[3] = 24'h000000;
    core_mode = 0;
    for (int rep = 0; rep < 2; rep++) begin
      run_a(25, -1, -1, -1, fd, drop);
      repeat (3) @(negedge clk);
      total++;
      if (a_sum !== 32'h01000002) begin
        bad++; $display("FAIL checksum_run%0d got=%h want=01000002", rep, a_sum);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_done_outside_collect();
    test_timeout();
    test_abort_and_busy_start();
    test_reset_mid_write();
    test_rd_lat3();
`ifdef FRAME_STREAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
